// File: rtl/bcd_divider.sv
// bcd_divider
//   Sequential divider paired with the shift-add multiplier. It accepts a
//   packed-BCD dividend and converts it to binary, one digit per clock. It then
//   performs restoring division by an N-bit binary divisor, one quotient bit
//   per clock.
// Ports
//   clk     : clock, all state updates on posedge
//   reset   : asynchronous active-low reset
//   start   : operation request, sampled only in IDLE
//   bcd_in  : packed-BCD dividend, 4*D bits, most significant digit in top nibble
//   b_in    : binary divisor, N bits
//   quo     : quotient, 2N bits (all ones on error)
//   rem     : remainder, N bits (zero on error)
//   busy    : operation in progress
//   finish  : result valid, held until the next accepted start
//   err     : 00 ok, 01 divide-by-zero, 10 bad BCD digit, 11 dividend overflow
module bcd_divider #(
    parameter int N = 8,
    parameter int D = ((N * 2) / 3) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4*D-1:0]   bcd_in,
    input  logic [N-1:0]     b_in,
    output logic [2*N-1:0]   quo,
    output logic [N-1:0]     rem,
    output logic             busy,
    output logic             finish,
    output logic [1:0]       err
);

    localparam int AW   = 2 * N + 4;
    localparam int CMAX = (2 * N > D) ? 2 * N : D;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [4*D-1:0]    bcd_q;
    logic [N-1:0]      b_q;
    logic [AW-1:0]     acc_q;
    logic [2*N-1:0]    dq_q;
    logic [N:0]        r_q;
    logic [CW-1:0]     cnt_q;
    logic [2*N-1:0]    quo_q;
    logic [N-1:0]      rem_q;
    logic              busy_q;
    logic              finish_q;
    logic [1:0]        err_q;

    logic [3:0]        digit_d;
    logic [AW-1:0]     acc_d;
    logic              ovf_d;
    logic [N:0]        r_sh_d;
    logic [N:0]        r_sub_d;
    logic              fits_d;

    always_comb begin
        digit_d = bcd_q[4*D-1 -: 4];
        // acc*10 built as acc*8 + acc*2; the value before the multiply never
        // exceeds 2^(2N)-1, so AW bits cannot wrap here.
        acc_d   = (acc_q << 3) + (acc_q << 1) + AW'(digit_d);
        ovf_d   = |acc_d[AW-1:2*N];
        // dq_q doubles as the dividend shifter and the quotient collector:
        // its MSB feeds the partial remainder while quotient bits enter at the LSB.
        r_sh_d  = {r_q[N-1:0], dq_q[2*N-1]};
        fits_d  = (r_sh_d >= {1'b0, b_q});
        r_sub_d = r_sh_d - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            dq_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q    <= bcd_in;
                        b_q      <= b_in;
                        acc_q    <= '0;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        finish_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (b_in == '0) begin
                            err_q   <= 2'b01;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 2'b00;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_q << 4;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (digit_d > 4'd9) begin
                        err_q   <= 2'b10;
                        state_q <= DONE;
                    end else if (ovf_d) begin
                        err_q   <= 2'b11;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(D - 1)) begin
                        dq_q    <= acc_d[2*N-1:0];
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    r_q   <= fits_d ? r_sub_d : r_sh_d;
                    dq_q  <= {dq_q[2*N-2:0], fits_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(2 * N - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (err_q != 2'b00) begin
                        quo_q <= '1;
                        rem_q <= '0;
                    end else begin
                        quo_q <= dq_q;
                        rem_q <= r_q[N-1:0];
                    end
                    busy_q   <= 1'b0;
                    finish_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quo    = quo_q;
    assign rem    = rem_q;
    assign busy   = busy_q;
    assign finish = finish_q;
    assign err    = err_q;

endmodule
